// File: rtl/alu_pkg.sv
// Shared definitions for the ALU writeback slice.
//   FLAG_W            width of the {Z,N,C,V} flag vector
//   FLAG_Z..FLAG_V    bit positions of each flag inside that vector
//   flags_t           flag vector type used by alu_flag_gen and alu_result_stage
package alu_pkg;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag derivation for one adder result, with optional
// saturation of the stored value on signed overflow.
// Configuration macro: ALU_RESULT_SAT_EN (defined = saturate on V=1).
// Ports:
//   sum     in   WIDTH  adder sum
//   cout    in   1      adder carry-out
//   a_msb   in   1      MSB of operand a
//   b_msb   in   1      MSB of operand b as seen by the adder
//   sub     in   1      1 = subtract (carry becomes borrow)
//   result  out  WIDTH  value to store (saturated when enabled)
//   flags   out  4      {Z,N,C,V}
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  logic v;

  // Signed overflow: like-signed operands producing a result of the other sign.
  assign v = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);

  always_comb begin
    result = sum;
`ifdef ALU_RESULT_SAT_EN
    // Clamp towards the sign of operand a: most negative or most positive.
    if (v) begin
      result = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Z and N follow the stored value; C and V describe the raw arithmetic.
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_C] = cout ^ sub;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered writeback stage behind the ripple adder: derives flags, buffers
// results in a DEPTH-entry FIFO and hands them to the register file through
// a valid/ready handshake. Keeps a sticky overflow bit for the control unit.
// Configuration macro: ALU_RESULT_SAT_EN (passed through to alu_flag_gen).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        producer handshake (in_ready = not full)
//   in_sum, in_cout          adder outputs
//   in_a_msb, in_b_msb       operand MSBs as seen by the adder
//   in_sub                   1 = SUB
//   out_valid/out_ready      consumer handshake
//   out_result, out_flags    head entry (last popped value when empty)
//   ovf_sticky, ovf_clr      sticky overflow status and its clear
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_result [DEPTH];
  flags_t           mem_flags  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] last_result;
  flags_t           last_flags;

  logic [WIDTH-1:0] gen_result;
  flags_t           gen_flags;
  logic             push;
  logic             pop;

  alu_flag_gen #(
    .WIDTH(WIDTH)
  ) u_flag_gen (
    .sum   (in_sum),
    .cout  (in_cout),
    .a_msb (in_a_msb),
    .b_msb (in_b_msb),
    .sub   (in_sub),
    .result(gen_result),
    .flags (gen_flags)
  );

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // When empty the read pointer may sit on stale storage, so the last popped
  // entry is held separately to keep the outputs steady.
  always_comb begin
    out_result = last_result;
    out_flags  = last_flags;
    if (out_valid) begin
      out_result = mem_result[rd_ptr];
      out_flags  = mem_flags[rd_ptr];
    end
  end

  // Storage needs no reset: it is never presented unless count says it is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= gen_result;
      mem_flags[wr_ptr]  <= gen_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_result <= '0;
      last_flags  <= '0;
      ovf_sticky  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        last_result <= mem_result[rd_ptr];
        last_flags  <= mem_flags[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new overflow outranks a clear in the same cycle.
      if (push && gen_flags[FLAG_V]) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule
